// File: rtl/syn_peak_pkg.sv
// Shared types and defaults for the syn_peak correlation-peak finder.
package syn_pkg;

    localparam int DW_DEF   = 14;
    localparam int CW_DEF   = 8;
    localparam int WW_DEF   = 4;
    localparam int HITS_MAX = 3;

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        ACQ    = 2'd1,
        TRACK  = 2'd2
    } state_t;

    // A programmed miss limit of zero behaves as a limit of one.
    function automatic logic [2:0] miss_limit(input logic [2:0] m);
        return (m == 3'd0) ? 3'd1 : m;
    endfunction

endpackage

// File: rtl/syn_peak_if.sv
// Correlation stream, configuration and sync result bundle for syn_peak.
interface syn_peak_if #(
    parameter int DW = 14,
    parameter int CW = 8,
    parameter int WW = 4
);
    logic [DW-1:0]      din;
    logic               iv;
    logic [DW-1:0]      thresh;
    logic [CW-1:0]      period;
    logic [WW-1:0]      win;
    logic [2:0]         maxmiss;
    logic               sync;
    logic [DW-1:0]      peak;
    logic signed [WW:0] offset;
    logic               lock;
    logic               ov;

    modport master (
        output din, iv, thresh, period, win, maxmiss,
        input  sync, peak, offset, lock, ov
    );

    modport slave (
        input  din, iv, thresh, period, win, maxmiss,
        output sync, peak, offset, lock, ov
    );
endinterface

// File: rtl/syn_peak_max.sv
// Windowed max tracker. Outputs already include the current sample so the
// caller can evaluate the window on its closing sample in the same cycle.
module syn_peak_max #(
    parameter int DW = 14,
    parameter int CW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          en,
    input  logic [DW-1:0] din,
    input  logic [CW-1:0] cnt,
    output logic [DW-1:0] pkmax,
    output logic [CW-1:0] pkpos,
    output logic          valid
);
    logic [DW-1:0] max_q;
    logic [CW-1:0] pos_q;
    logic          valid_q;
    logic          upd;

    // Strictly greater keeps the earliest of equal samples.
    assign upd   = en && (!valid_q || (din > max_q));
    assign pkmax = upd ? din : max_q;
    assign pkpos = upd ? cnt : pos_q;
    assign valid = valid_q || upd;

    // Max/position registers, cleared when a window closes.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            max_q   <= '0;
            pos_q   <= '0;
            valid_q <= 1'b0;
        end else if (clr) begin
            max_q   <= '0;
            pos_q   <= '0;
            valid_q <= 1'b0;
        end else if (upd) begin
            max_q   <= din;
            pos_q   <= cnt;
            valid_q <= 1'b1;
        end
    end
endmodule

// File: rtl/syn_peak.sv
// Sync peak finder: flywheels a sample counter at the expected sync period,
// picks the largest above-threshold sample in each window and reports it as a
// sync strobe with its timing offset; lock uses hit/miss hysteresis.
// Build option SYN_PEAK_FLYWHEEL_EN: a miss while locked still pulses sync
// (peak=0, offset=0) so downstream timing keeps running.
//
// state  | meaning
// SEARCH | waiting for first sample at/above threshold
// ACQ    | first window open, 2*win+1 samples from the trigger sample
// TRACK  | window around nominal period, hit/miss accounting
module syn_peak
    import syn_pkg::*;
#(
    parameter int DW = DW_DEF,
    parameter int CW = CW_DEF,
    parameter int WW = WW_DEF
) (
    input logic       clk,
    input logic       rst,
    syn_peak_if.slave bus
);
    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [1:0]       hits_q, hits_d;
    logic [2:0]       misses_q, misses_d;
    logic             lock_q, lock_d;
    logic             sync_q, sync_d;
    logic             ov_q, ov_d;
    logic [DW-1:0]    peak_q, peak_d;
    logic [WW:0]      offset_q, offset_d;

    logic             trk_en, trk_clr;
    logic [DW-1:0]    pkmax;
    logic [CW-1:0]    pkpos;
    logic             pkvalid;
    logic             qual;
    logic             acq_close, trk_close;
    logic [CW-1:0]    win_c, twowin_c, lo_c, hi_c;
    logic [1:0]       hits_inc;
    logic [2:0]       misses_inc;

    assign qual       = bus.din >= bus.thresh;
    assign win_c      = CW'(bus.win);
    assign twowin_c   = win_c + win_c;
    assign lo_c       = bus.period - win_c;
    assign hi_c       = bus.period + win_c;
    assign hits_inc   = (hits_q == 2'(HITS_MAX)) ? hits_q : hits_q + 2'd1;
    assign misses_inc = misses_q + 3'd1;

    syn_peak_max #(.DW(DW), .CW(CW)) u_max (
        .clk   (clk),
        .rst   (rst),
        .clr   (trk_clr),
        .en    (trk_en),
        .din   (bus.din),
        .cnt   (cnt_q),
        .pkmax (pkmax),
        .pkpos (pkpos),
        .valid (pkvalid)
    );

    // State and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= SEARCH;
            cnt_q    <= '0;
            hits_q   <= '0;
            misses_q <= '0;
            lock_q   <= 1'b0;
            sync_q   <= 1'b0;
            ov_q     <= 1'b0;
            peak_q   <= '0;
            offset_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            hits_q   <= hits_d;
            misses_q <= misses_d;
            lock_q   <= lock_d;
            sync_q   <= sync_d;
            ov_q     <= ov_d;
            peak_q   <= peak_d;
            offset_q <= offset_d;
        end
    end

    // Window sequencing, peak acceptance and lock accounting per valid sample.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        hits_d    = hits_q;
        misses_d  = misses_q;
        lock_d    = lock_q;
        sync_d    = 1'b0;
        ov_d      = 1'b0;
        peak_d    = peak_q;
        offset_d  = offset_q;
        trk_en    = 1'b0;
        trk_clr   = 1'b0;
        acq_close = 1'b0;
        trk_close = 1'b0;

        if (bus.iv) begin
            unique case (state_q)
                SEARCH: begin
                    if (qual) begin
                        trk_en = 1'b1;
                        if (win_c == '0) begin
                            acq_close = 1'b1;
                        end else begin
                            state_d = ACQ;
                            cnt_d   = CW'(1);
                        end
                    end
                end
                ACQ: begin
                    trk_en = qual;
                    if (cnt_q == twowin_c) acq_close = 1'b1;
                    else                   cnt_d     = cnt_q + CW'(1);
                end
                TRACK: begin
                    trk_en = qual && (cnt_q >= lo_c);
                    if (cnt_q == hi_c) trk_close = 1'b1;
                    else               cnt_d     = cnt_q + CW'(1);
                end
                default: state_d = SEARCH;
            endcase
        end

        if (acq_close) begin
            trk_clr  = 1'b1;
            sync_d   = 1'b1;
            ov_d     = 1'b1;
            peak_d   = pkmax;
            offset_d = '0;
            hits_d   = 2'd1;
            misses_d = '0;
            cnt_d    = twowin_c - pkpos + CW'(1);
            state_d  = TRACK;
        end

        if (trk_close) begin
            trk_clr = 1'b1;
            ov_d    = 1'b1;
            if (pkvalid) begin
                sync_d   = 1'b1;
                peak_d   = pkmax;
                offset_d = (WW+1)'(pkpos - bus.period);
                hits_d   = hits_inc;
                misses_d = '0;
                lock_d   = lock_q || (hits_inc >= 2'd2);
                cnt_d    = hi_c - pkpos + CW'(1);
            end else begin
`ifdef SYN_PEAK_FLYWHEEL_EN
                if (lock_q) begin
                    sync_d   = 1'b1;
                    peak_d   = '0;
                    offset_d = '0;
                end
`endif
                hits_d = '0;
                if (misses_inc >= miss_limit(bus.maxmiss)) begin
                    lock_d   = 1'b0;
                    misses_d = '0;
                    cnt_d    = '0;
                    state_d  = SEARCH;
                end else begin
                    misses_d = misses_inc;
                    cnt_d    = win_c + CW'(1);
                end
            end
        end
    end

    assign bus.sync   = sync_q;
    assign bus.ov     = ov_q;
    assign bus.peak   = peak_q;
    assign bus.offset = offset_q;
    assign bus.lock   = lock_q;
endmodule
